// File: rtl/branch_resolver.sv
// Resolve-side companion to the BTB predictor: queues in-flight {pc, npc} predictions,
// checks them against execute, and emits flush/redirect plus a BTB write. Optional stats: BR_STATS_EN.
module branch_resolver #(
  parameter int WORD_SIZE = 16,
  parameter int DEPTH     = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 pred_valid,
  input  logic [WORD_SIZE-1:0] pred_pc,
  input  logic [WORD_SIZE-1:0] pred_npc,
  output logic                 pred_ready,
  input  logic                 res_valid,
  input  logic                 res_is_branch,
  input  logic                 res_taken,
  input  logic [WORD_SIZE-1:0] res_target,
  output logic                 res_ready,
  output logic                 flush,
  output logic [WORD_SIZE-1:0] redirect_pc,
  output logic                 update_tag,
  output logic [WORD_SIZE-1:0] pc_collided,
  output logic [WORD_SIZE-1:0] branch_target
`ifdef BR_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0] n_branches,
  output logic [CNT_WIDTH-1:0] n_mispredicts
`endif
);

  localparam int              PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W:0]  FULL_CNT = (PTR_W + 1)'(DEPTH);

  // Unsupported sizes (non power of two, fewer than 2 entries) leave this marker in the hierarchy.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || CNT_WIDTH < 1) begin : g_bad_params
  end

  function automatic logic [WORD_SIZE-1:0] seq_pc(input logic [WORD_SIZE-1:0] pc);
    return pc + WORD_SIZE'(1);
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return ptr + PTR_W'(1);
  endfunction

`ifdef BR_STATS_EN
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] cnt);
    return (&cnt) ? cnt : cnt + CNT_WIDTH'(1);
  endfunction
`endif

  logic [WORD_SIZE-1:0] pc_mem  [DEPTH];
  logic [WORD_SIZE-1:0] npc_mem [DEPTH];
  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W:0]       count;

  logic                 push_p0;
  logic                 pop_p0;
  logic [WORD_SIZE-1:0] head_pc_p0;
  logic [WORD_SIZE-1:0] head_npc_p0;
  logic [WORD_SIZE-1:0] actual_p0;
  logic                 mispredict_p0;

  // ---- p0: handshake, head compare, mispredict decision ----
  assign pred_ready = (count != FULL_CNT) && !flush;
  assign res_ready  = (count != '0) && !flush;

  always_comb begin
    head_pc_p0    = pc_mem[rd_ptr];
    head_npc_p0   = npc_mem[rd_ptr];
    pop_p0        = res_valid && res_ready;
    actual_p0     = (res_is_branch && res_taken) ? res_target : seq_pc(head_pc_p0);
    mispredict_p0 = pop_p0 && (actual_p0 != head_npc_p0);
    // A push racing a mispredicting pop is wrong-path and never lands.
    push_p0       = pred_valid && pred_ready && !mispredict_p0;
  end

  always_ff @(posedge clk) begin
    if (push_p0) begin
      pc_mem[wr_ptr]  <= pred_pc;
      npc_mem[wr_ptr] <= pred_npc;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (mispredict_p0) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (push_p0) wr_ptr <= ptr_inc(wr_ptr);
      if (pop_p0)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push_p0, pop_p0})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // ---- p1: registered flush/redirect and BTB write strobe ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flush         <= 1'b0;
      update_tag    <= 1'b0;
      redirect_pc   <= '0;
      pc_collided   <= '0;
      branch_target <= '0;
    end else begin
      flush      <= mispredict_p0;
      update_tag <= mispredict_p0;
      if (mispredict_p0) begin
        redirect_pc   <= actual_p0;
        pc_collided   <= head_pc_p0;
        branch_target <= actual_p0;
      end
    end
  end

`ifdef BR_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      n_branches    <= '0;
      n_mispredicts <= '0;
    end else begin
      if (pop_p0 && res_is_branch) n_branches    <= sat_inc(n_branches);
      if (mispredict_p0)           n_mispredicts <= sat_inc(n_mispredicts);
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Directed + randomized bench for branch_resolver against a queue-based reference model.
module tb_branch_resolver;
  localparam int W  = 16;
  localparam int D  = 4;
  localparam int CW = 16;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         pred_valid = 1'b0;
  logic [W-1:0] pred_pc = '0;
  logic [W-1:0] pred_npc = '0;
  logic         pred_ready;
  logic         res_valid = 1'b0;
  logic         res_is_branch = 1'b0;
  logic         res_taken = 1'b0;
  logic [W-1:0] res_target = '0;
  logic         res_ready;
  logic         flush;
  logic [W-1:0] redirect_pc;
  logic         update_tag;
  logic [W-1:0] pc_collided;
  logic [W-1:0] branch_target;
`ifdef BR_STATS_EN
  logic [CW-1:0] n_branches;
  logic [CW-1:0] n_mispredicts;
`endif

  branch_resolver #(.WORD_SIZE(W), .DEPTH(D), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset_n(reset_n),
    .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_npc(pred_npc), .pred_ready(pred_ready),
    .res_valid(res_valid), .res_is_branch(res_is_branch), .res_taken(res_taken),
    .res_target(res_target), .res_ready(res_ready),
    .flush(flush), .redirect_pc(redirect_pc), .update_tag(update_tag),
    .pc_collided(pc_collided), .branch_target(branch_target)
`ifdef BR_STATS_EN
    , .n_branches(n_branches), .n_mispredicts(n_mispredicts)
`endif
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: in-flight predictions as plain queues, outputs as last strobed values.
  logic [W-1:0] q_pc[$];
  logic [W-1:0] q_npc[$];
  logic         m_flush, m_upd;
  logic [W-1:0] m_redir, m_pcc, m_bt;
  int           m_nbr, m_nmis;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q_pc.delete();
    q_npc.delete();
    m_flush = 1'b0; m_upd = 1'b0;
    m_redir = '0; m_pcc = '0; m_bt = '0;
    m_nbr = 0; m_nmis = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pred_ready"}, 32'(pred_ready), 32'((q_pc.size() != D) && !m_flush));
    chk({tag, ".res_ready"},  32'(res_ready),  32'((q_pc.size() != 0) && !m_flush));
    chk({tag, ".flush"},      32'(flush),      32'(m_flush));
    chk({tag, ".update_tag"}, 32'(update_tag), 32'(m_upd));
    chk({tag, ".redirect"},   32'(redirect_pc),   32'(m_redir));
    chk({tag, ".pc_coll"},    32'(pc_collided),   32'(m_pcc));
    chk({tag, ".br_tgt"},     32'(branch_target), 32'(m_bt));
`ifdef BR_STATS_EN
    chk({tag, ".n_br"},  32'(n_branches),    32'(m_nbr));
    chk({tag, ".n_mis"}, 32'(n_mispredicts), 32'(m_nmis));
`endif
  endtask

  // One clock: drive inputs, advance the model by the specification's rules, check after the edge.
  task automatic cyc(input logic pv, input logic [W-1:0] ppc, input logic [W-1:0] pnpc,
                     input logic rv, input logic rb, input logic rt, input logic [W-1:0] rtgt,
                     input string tag);
    logic         can_push, can_pop, mis;
    logic [W-1:0] actual;
    pred_valid = pv; pred_pc = ppc; pred_npc = pnpc;
    res_valid = rv; res_is_branch = rb; res_taken = rt; res_target = rtgt;
    can_push = pv && (q_pc.size() < D) && !m_flush;
    can_pop  = rv && (q_pc.size() > 0) && !m_flush;
    mis = 1'b0;
    actual = '0;
    if (can_pop) begin
      actual = (rb && rt) ? rtgt : q_pc[0] + W'(1);
      mis = (actual != q_npc[0]);
      if (rb && m_nbr < (1 << CW) - 1) m_nbr++;
      if (mis && m_nmis < (1 << CW) - 1) m_nmis++;
    end
    m_flush = mis;
    m_upd   = mis;
    if (mis) begin
      m_redir = actual; m_pcc = q_pc[0]; m_bt = actual;
      q_pc.delete(); q_npc.delete();
    end else begin
      if (can_pop) begin void'(q_pc.pop_front()); void'(q_npc.pop_front()); end
      if (can_push) begin q_pc.push_back(ppc); q_npc.push_back(pnpc); end
    end
    @(posedge clk); #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, '0, tag);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    check_all("post_reset");

    // 1: reset mid-run with two entries queued
    cyc(1'b1, 16'h0008, 16'h0009, 1'b0, 1'b0, 1'b0, '0, "t1_push0");
    cyc(1'b1, 16'h0009, 16'h000A, 1'b0, 1'b0, 1'b0, '0, "t1_push1");
    pred_valid = 1'b0;
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    chk("t1_in_reset.pred_ready", 32'(pred_ready), 32'd1);
    chk("t1_in_reset.res_ready",  32'(res_ready),  32'd0);
    check_all("t1_in_reset");
    @(posedge clk); #1 reset_n = 1'b1;
    cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, '0, "t1_stale");
    chk("t1_stale.res_ready", 32'(res_ready), 32'd0);

    // 2: correct fall-through
    cyc(1'b1, 16'h0010, 16'h0011, 1'b0, 1'b0, 1'b0, '0, "t2_push");
    cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, '0, "t2_res");
    chk("t2.flush", 32'(flush), 32'd0);
    chk("t2.update_tag", 32'(update_tag), 32'd0);
    chk("t2.res_ready", 32'(res_ready), 32'd0);

    // 3: taken but not predicted
    cyc(1'b1, 16'h0020, 16'h0021, 1'b0, 1'b0, 1'b0, '0, "t3_push");
    cyc(1'b0, '0, '0, 1'b1, 1'b1, 1'b1, 16'h0040, "t3_res");
    chk("t3.flush", 32'(flush), 32'd1);
    chk("t3.redirect", 32'(redirect_pc), 32'h0040);
    chk("t3.update_tag", 32'(update_tag), 32'd1);
    chk("t3.pc_coll", 32'(pc_collided), 32'h0020);
    chk("t3.br_tgt", 32'(branch_target), 32'h0040);
    idle("t3_after");
    chk("t3_after.flush", 32'(flush), 32'd0);
    chk("t3_after.update_tag", 32'(update_tag), 32'd0);

    // 4: predicted taken, resolved not taken
    cyc(1'b1, 16'h0030, 16'h0050, 1'b0, 1'b0, 1'b0, '0, "t4_push");
    cyc(1'b0, '0, '0, 1'b1, 1'b1, 1'b0, 16'h0050, "t4_res");
    chk("t4.flush", 32'(flush), 32'd1);
    chk("t4.redirect", 32'(redirect_pc), 32'h0031);
    chk("t4.update_tag", 32'(update_tag), 32'd1);
    chk("t4.br_tgt", 32'(branch_target), 32'h0031);
    idle("t4_after");

    // 5: fill, overflow push, then squash while pushing
    for (int i = 0; i < D; i++)
      cyc(1'b1, W'(16'h0100 + i), W'(16'h0101 + i), 1'b0, 1'b0, 1'b0, '0, "t5_fill");
    chk("t5_full.pred_ready", 32'(pred_ready), 32'd0);
    cyc(1'b1, 16'h0104, 16'h0105, 1'b0, 1'b0, 1'b0, '0, "t5_over");
    cyc(1'b1, 16'h0104, 16'h0105, 1'b1, 1'b1, 1'b1, 16'h0200, "t5_squash");
    chk("t5_squash.flush", 32'(flush), 32'd1);
    chk("t5_squash.pred_ready", 32'(pred_ready), 32'd0);
    chk("t5_squash.redirect", 32'(redirect_pc), 32'h0200);
    chk("t5_squash.pc_coll", 32'(pc_collided), 32'h0100);
    idle("t5_next");
    chk("t5_next.pred_ready", 32'(pred_ready), 32'd1);
    chk("t5_next.res_ready", 32'(res_ready), 32'd0);
`ifdef BR_STATS_EN
    chk("t5.n_branches", 32'(n_branches), 32'd3);
    chk("t5.n_mispredicts", 32'(n_mispredicts), 32'd3);
`endif

    // 6: PC wrap on fall-through
    cyc(1'b1, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b0, '0, "t6_push");
    cyc(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, '0, "t6_res");
    chk("t6.flush", 32'(flush), 32'd0);
    chk("t6.res_ready", 32'(res_ready), 32'd0);

    // Randomized traffic with one asynchronous reset in the middle
    for (int n = 0; n < 600; n++) begin
      logic [W-1:0] pc, npc, tgt;
      logic [W-1:0] tgts [4];
      tgts[0] = 16'h0040; tgts[1] = 16'h0080; tgts[2] = 16'hFFFF; tgts[3] = 16'h0000;
      pc  = ($urandom_range(0, 7) == 0) ? 16'hFFFF : W'($urandom);
      npc = ($urandom_range(0, 2) != 0) ? pc + W'(1) : tgts[$urandom_range(0, 3)];
      tgt = tgts[$urandom_range(0, 3)];
      if (n == 300) begin
        #2 reset_n = 1'b0;
        model_reset();
        #1 check_all("rnd_in_reset");
        @(posedge clk); #1 reset_n = 1'b1;
      end
      cyc(($urandom_range(0, 9) < 7), pc, npc, ($urandom_range(0, 1) == 1),
          ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1), tgt, "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
